// File: rtl/generic_ahb_master_if.sv
// Generic memory-side bus shared between the I/D arbiter and the AHB-Lite master.
// The generic_bus modport is the slave side; cpu is the requester side.
interface generic_bus_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ren;
   logic        wen;
   logic        busy;
   logic [3:0]  byte_en;

   modport generic_bus (
      input  addr, wdata, ren, wen, byte_en,
      output rdata, busy
   );

   modport cpu (
      output addr, wdata, ren, wen, byte_en,
      input  rdata, busy
   );
endinterface

// File: rtl/generic_ahb_master.sv
// Generic-bus to AHB-Lite bridge: one non-pipelined single transfer per request,
// with byte-lane to HSIZE translation, error-response handling and a wait-state timeout.
module generic_ahb_master #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       TIMEOUT  = 1024,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hBAD1_BAD1
) (
   input  logic                  CLK,
   input  logic                  nRST,
   generic_bus_if.generic_bus    gen_bus_if,
   output logic [ADDR_W-1:0]     HADDR,
   output logic                  HWRITE,
   output logic [1:0]            HTRANS,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic [DATA_W-1:0]     HWDATA,
   input  logic [DATA_W-1:0]     HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP,
   output logic                  bus_error
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {IDLE, DATA, ERROR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic              hwrite_q, hwrite_d;
   logic [2:0]        hsize_q, hsize_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              req;
   logic [2:0]        req_size;
   logic [1:0]        req_lane;
   logic [ADDR_W-1:0] req_addr;
   logic              timed_out;
   logic              busy_c;
   logic [DATA_W-1:0] rdata_c;

   assign HBURST = 3'b000;
   assign HPROT  = 4'b0011;

   assign req       = gen_bus_if.ren | gen_bus_if.wen;
   assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

   // Contiguous aligned lane groups map to a narrow transfer; anything else goes out as a word.
   always_comb begin
      req_size = 3'd2;
      req_lane = 2'b00;
      case (gen_bus_if.byte_en)
         4'b1111: begin req_size = 3'd2; req_lane = 2'b00; end
         4'b0011: begin req_size = 3'd1; req_lane = 2'b00; end
         4'b1100: begin req_size = 3'd1; req_lane = 2'b10; end
         4'b0001: begin req_size = 3'd0; req_lane = 2'b00; end
         4'b0010: begin req_size = 3'd0; req_lane = 2'b01; end
         4'b0100: begin req_size = 3'd0; req_lane = 2'b10; end
         4'b1000: begin req_size = 3'd0; req_lane = 2'b11; end
         default: begin req_size = 3'd2; req_lane = 2'b00; end
      endcase
   end

   assign req_addr = {gen_bus_if.addr[ADDR_W-1:2], req_lane};

   always_comb begin
      state_d  = state_q;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (req && HREADY) begin
               state_d  = DATA;
               haddr_d  = req_addr;
               hwrite_d = gen_bus_if.wen;
               hsize_d  = req_size;
               cnt_d    = '0;
            end
         end
         DATA: begin
            if (HREADY || timed_out) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (HRESP) begin
               state_d = ERROR;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ERROR: begin
            if (HREADY) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hsize_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
         cnt_q    <= cnt_d;
      end
   end

   // Outputs are combinational so completion and read data land in the data-phase cycle;
   // gating with nRST forces the reset values without waiting for a clock.
   always_comb begin
      HTRANS    = HTRANS_IDLE;
      HADDR     = '0;
      HWRITE    = 1'b0;
      HSIZE     = '0;
      HWDATA    = '0;
      busy_c    = 1'b1;
      rdata_c   = '0;
      bus_error = 1'b0;
      if (nRST) begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  HTRANS = HTRANS_NONSEQ;
                  HADDR  = req_addr;
                  HWRITE = gen_bus_if.wen;
                  HSIZE  = req_size;
               end
            end
            DATA: begin
               HADDR  = haddr_q;
               HWRITE = hwrite_q;
               HSIZE  = hsize_q;
               HWDATA = gen_bus_if.wdata;
               if (HREADY) begin
                  busy_c = 1'b0;
                  if (HRESP) begin
                     bus_error = 1'b1;
                     if (!hwrite_q) rdata_c = ERR_DATA;
                  end else if (!hwrite_q) begin
                     rdata_c = HRDATA;
                  end
               end else if (timed_out) begin
                  busy_c    = 1'b0;
                  bus_error = 1'b1;
                  if (!hwrite_q) rdata_c = ERR_DATA;
               end
            end
            ERROR: begin
               HADDR  = haddr_q;
               HWRITE = hwrite_q;
               HSIZE  = hsize_q;
               HWDATA = gen_bus_if.wdata;
               if (HREADY) begin
                  busy_c    = 1'b0;
                  bus_error = 1'b1;
                  if (!hwrite_q) rdata_c = ERR_DATA;
               end
            end
            default: ;
         endcase
      end
   end

   assign gen_bus_if.busy  = busy_c;
   assign gen_bus_if.rdata = rdata_c;

endmodule
